// File: rtl/data_arbiter_2x1.sv
// Two-master sram-like data arbiter: cached (ram_*) vs uncached (conf_*) onto one AXI-side port.
// An owner FIFO steers in-order data_ok/rdata back to the master that issued each transaction.
module data_arbiter_2x1 #(
  parameter int unsigned OUTSTANDING    = 4,
  parameter int unsigned MAX_RAM_STREAK = 8
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ram_data_req,
  input  logic        ram_data_wr,
  input  logic [1:0]  ram_data_size,
  input  logic [31:0] ram_data_addr,
  input  logic [31:0] ram_data_wdata,
  output logic [31:0] ram_data_rdata,
  output logic        ram_data_addr_ok,
  output logic        ram_data_data_ok,

  input  logic        conf_data_req,
  input  logic        conf_data_wr,
  input  logic [1:0]  conf_data_size,
  input  logic [31:0] conf_data_addr,
  input  logic [31:0] conf_data_wdata,
  output logic [31:0] conf_data_rdata,
  output logic        conf_data_addr_ok,
  output logic        conf_data_data_ok,

  output logic        wrap_data_req,
  output logic        wrap_data_wr,
  output logic [1:0]  wrap_data_size,
  output logic [31:0] wrap_data_addr,
  output logic [31:0] wrap_data_wdata,
  input  logic [31:0] wrap_data_rdata,
  input  logic        wrap_data_addr_ok,
  input  logic        wrap_data_data_ok
);

  localparam int unsigned PtrW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(OUTSTANDING) + 1;
  localparam int unsigned StrW = $clog2(MAX_RAM_STREAK + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(OUTSTANDING);
  localparam logic [StrW-1:0] StrMax  = StrW'(MAX_RAM_STREAK);

  logic                   lock_q, lock_d;
  logic                   lock_owner_q, lock_owner_d;
  logic [StrW-1:0]        streak_q, streak_d;
  logic [OUTSTANDING-1:0] owner_q, owner_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;

  logic grant;      // 0 = cached, 1 = uncached
  logic grant_req;
  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic pop;
  logic head;

  always_comb begin
    grant = 1'b0;
    if (lock_q) begin
      grant = lock_owner_q;
    end else if (conf_data_req && !ram_data_req) begin
      grant = 1'b1;
    end else if (conf_data_req && ram_data_req) begin
      grant = (streak_q >= StrMax);
    end
  end

  assign grant_req  = grant ? conf_data_req : ram_data_req;
  assign fifo_full  = (count_q == CntFull);
  assign fifo_empty = (count_q == '0);

  // Request path: zero-cycle pass-through of the granted master.
  assign wrap_data_req   = grant_req & ~fifo_full & ~rst;
  assign wrap_data_wr    = grant ? conf_data_wr    : ram_data_wr;
  assign wrap_data_size  = grant ? conf_data_size  : ram_data_size;
  assign wrap_data_addr  = grant ? conf_data_addr  : ram_data_addr;
  assign wrap_data_wdata = grant ? conf_data_wdata : ram_data_wdata;

  assign ram_data_addr_ok  = ~grant & wrap_data_addr_ok & ~fifo_full & ~rst;
  assign conf_data_addr_ok =  grant & wrap_data_addr_ok & ~fifo_full & ~rst;

  assign accept = wrap_data_req & wrap_data_addr_ok;

  // Response path: a data_ok with nothing outstanding is dropped.
  assign head = owner_q[rd_ptr_q];
  assign pop  = wrap_data_data_ok & ~fifo_empty & ~rst;

  assign ram_data_data_ok  = pop & ~head;
  assign conf_data_data_ok = pop &  head;
  assign ram_data_rdata    = wrap_data_rdata;
  assign conf_data_rdata   = wrap_data_rdata;

  always_comb begin
    lock_d       = grant_req & ~accept;
    lock_owner_d = lock_owner_q;
    streak_d     = streak_q;
    owner_d      = owner_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    if (grant_req && !accept) begin
      lock_owner_d = grant;
    end

    if (accept && grant) begin
      streak_d = '0;
    end else if (!conf_data_req) begin
      streak_d = '0;
    end else if (accept && (streak_q != StrMax)) begin
      streak_d = streak_q + StrW'(1);
    end

    if (accept) begin
      owner_d[wr_ptr_q] = grant;
      wr_ptr_d          = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      streak_q     <= '0;
      owner_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      streak_q     <= streak_d;
      owner_q      <= owner_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // A response with no transaction outstanding means the slave is out of sync.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(wrap_data_data_ok && fifo_empty));
    end
  end

endmodule

// File: tb/tb_data_arbiter_2x1.sv
// Self-checking bench for data_arbiter_2x1: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the arbitration rules.
module tb_data_arbiter_2x1;

  localparam int Outs      = 4;
  localparam int MaxStreak = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rr, rwr, cr, cwr, waok, wdok;
  logic [1:0]  rsz, csz;
  logic [31:0] raddr, rwd, caddr, cwd, wrd;

  logic [31:0] ram_data_rdata, conf_data_rdata;
  logic        ram_data_addr_ok, ram_data_data_ok, conf_data_addr_ok, conf_data_data_ok;
  logic        wrap_data_req, wrap_data_wr;
  logic [1:0]  wrap_data_size;
  logic [31:0] wrap_data_addr, wrap_data_wdata;

  data_arbiter_2x1 #(
    .OUTSTANDING    (Outs),
    .MAX_RAM_STREAK (MaxStreak)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ram_data_req      (rr),
    .ram_data_wr       (rwr),
    .ram_data_size     (rsz),
    .ram_data_addr     (raddr),
    .ram_data_wdata    (rwd),
    .ram_data_rdata    (ram_data_rdata),
    .ram_data_addr_ok  (ram_data_addr_ok),
    .ram_data_data_ok  (ram_data_data_ok),
    .conf_data_req     (cr),
    .conf_data_wr      (cwr),
    .conf_data_size    (csz),
    .conf_data_addr    (caddr),
    .conf_data_wdata   (cwd),
    .conf_data_rdata   (conf_data_rdata),
    .conf_data_addr_ok (conf_data_addr_ok),
    .conf_data_data_ok (conf_data_data_ok),
    .wrap_data_req     (wrap_data_req),
    .wrap_data_wr      (wrap_data_wr),
    .wrap_data_size    (wrap_data_size),
    .wrap_data_addr    (wrap_data_addr),
    .wrap_data_wdata   (wrap_data_wdata),
    .wrap_data_rdata   (wrd),
    .wrap_data_addr_ok (waok),
    .wrap_data_data_ok (wdok)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: owners of outstanding transactions, pending-request holder, cached streak.
  bit m_owner[$];
  bit m_lock;
  bit m_lock_owner;
  int m_streak;
  bit acc_r;
  bit acc_c;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit g, greq, full, empty, e_wreq, acc, pop;
    if (rst) begin
      chk1("rst_wrap_req", wrap_data_req, 1'b0);
      chk1("rst_ram_addr_ok", ram_data_addr_ok, 1'b0);
      chk1("rst_conf_addr_ok", conf_data_addr_ok, 1'b0);
      chk1("rst_ram_data_ok", ram_data_data_ok, 1'b0);
      chk1("rst_conf_data_ok", conf_data_data_ok, 1'b0);
      m_owner.delete();
      m_lock       = 1'b0;
      m_lock_owner = 1'b0;
      m_streak     = 0;
      acc_r        = 1'b0;
      acc_c        = 1'b0;
    end else begin
      full  = (m_owner.size() == Outs);
      empty = (m_owner.size() == 0);
      if (m_lock)        g = m_lock_owner;
      else if (rr && cr) g = (m_streak >= MaxStreak);
      else               g = cr;
      greq   = g ? cr : rr;
      e_wreq = greq && !full;
      acc    = e_wreq && waok;
      pop    = wdok && !empty;

      chk1("wrap_req", wrap_data_req, e_wreq);
      chk1("ram_addr_ok", ram_data_addr_ok, !g && waok && !full);
      chk1("conf_addr_ok", conf_data_addr_ok, g && waok && !full);
      if (e_wreq) begin
        chk32("wrap_addr", wrap_data_addr, g ? caddr : raddr);
        chk1("wrap_wr", wrap_data_wr, g ? cwr : rwr);
        chk32("wrap_size", {30'b0, wrap_data_size}, {30'b0, (g ? csz : rsz)});
        chk32("wrap_wdata", wrap_data_wdata, g ? cwd : rwd);
      end
      chk1("ram_data_ok", ram_data_data_ok, pop && !m_owner[0]);
      chk1("conf_data_ok", conf_data_data_ok, pop && m_owner[0]);
      if (pop && !m_owner[0]) chk32("ram_rdata", ram_data_rdata, wrd);
      if (pop && m_owner[0])  chk32("conf_rdata", conf_data_rdata, wrd);

      acc_r = acc && !g;
      acc_c = acc && g;
      if (pop) void'(m_owner.pop_front());
      if (acc) m_owner.push_back(g);
      m_lock       = greq && !acc;
      m_lock_owner = g;
      if (acc && g)                          m_streak = 0;
      else if (!cr)                          m_streak = 0;
      else if (acc && m_streak < MaxStreak)  m_streak = m_streak + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drain();
    repeat (8) begin
      wdok = (m_owner.size() != 0);
      wrd  = $urandom;
      step();
    end
    wdok = 1'b0;
  endtask

  int run;
  int nunc;

  initial begin
    rst = 1'b1;
    rr = 0; rwr = 0; rsz = 2'd2; raddr = '0; rwd = '0;
    cr = 0; cwr = 0; csz = 2'd2; caddr = '0; cwd = '0;
    waok = 0; wdok = 0; wrd = '0;
    repeat (3) step();
    rst = 1'b0;

    // Single-master latency
    rr = 1; rwr = 0; rsz = 2'd2; raddr = 32'h1FC0_0100; waok = 1;
    settle();
    chk1("t1_addr_ok", ram_data_addr_ok, 1'b1);
    chk32("t1_wrap_addr", wrap_data_addr, 32'h1FC0_0100);
    step(); rr = 0; waok = 0;
    step(); step();
    wdok = 1; wrd = 32'hDEAD_BEEF;
    settle();
    chk1("t1_ram_data_ok", ram_data_data_ok, 1'b1);
    chk32("t1_ram_rdata", ram_data_rdata, 32'hDEAD_BEEF);
    chk1("t1_conf_data_ok", conf_data_data_ok, 1'b0);
    step(); wdok = 0;

    // Contention with lock
    rr = 1; rwr = 1; raddr = 32'hA000_0010; rwd = 32'h5555_AAAA;
    cr = 1; cwr = 0; caddr = 32'hBFD0_0020; waok = 0;
    settle();
    chk32("t2_addr_c0", wrap_data_addr, 32'hA000_0010);
    chk1("t2_no_accept_c0", ram_data_addr_ok, 1'b0);
    step(); cr = 0;
    settle();
    chk32("t2_addr_c1", wrap_data_addr, 32'hA000_0010);
    step(); cr = 1; waok = 1;
    settle();
    chk32("t2_addr_c2", wrap_data_addr, 32'hA000_0010);
    chk1("t2_ram_accept", ram_data_addr_ok, 1'b1);
    chk1("t2_conf_wait", conf_data_addr_ok, 1'b0);
    step(); rr = 0;
    settle();
    chk1("t2_conf_accept", conf_data_addr_ok, 1'b1);
    chk32("t2_conf_addr", wrap_data_addr, 32'hBFD0_0020);
    step(); cr = 0; waok = 0;
    wdok = 1; wrd = 32'h0000_00A1;
    settle();
    chk1("t2_ret0_ram", ram_data_data_ok, 1'b1);
    step(); wrd = 32'h0000_00B2;
    settle();
    chk1("t2_ret1_conf", conf_data_data_ok, 1'b1);
    step(); wdok = 0;

    // Interleaved in-order return
    rr = 1; rwr = 0; raddr = 32'h0000_1000; waok = 1;
    settle(); chk1("t3_acc0", ram_data_addr_ok, 1'b1);
    step(); rr = 0; cr = 1; caddr = 32'hBFD0_1000;
    settle(); chk1("t3_acc1", conf_data_addr_ok, 1'b1);
    step(); cr = 0; rr = 1; raddr = 32'h0000_2000;
    settle(); chk1("t3_acc2", ram_data_addr_ok, 1'b1);
    step(); rr = 0; waok = 0; wdok = 1; wrd = 32'h11;
    settle();
    chk1("t3_ret0_ram", ram_data_data_ok, 1'b1);
    chk32("t3_ret0_data", ram_data_rdata, 32'h11);
    step(); wrd = 32'h22;
    settle();
    chk1("t3_ret1_conf", conf_data_data_ok, 1'b1);
    chk1("t3_ret1_not_ram", ram_data_data_ok, 1'b0);
    chk32("t3_ret1_data", conf_data_rdata, 32'h22);
    step(); wrd = 32'h33;
    settle();
    chk1("t3_ret2_ram", ram_data_data_ok, 1'b1);
    chk32("t3_ret2_data", ram_data_rdata, 32'h33);
    step(); wdok = 0;

    // Fairness: 8 cached grants, then one uncached
    rr = 1; cr = 1; waok = 1; run = 0; nunc = 0;
    repeat (60) begin
      step();
      if (acc_r) begin run++; raddr = $urandom; end
      if (acc_c) begin
        chk32("t4_fair_gap", run, 32'd8);
        run = 0; nunc++; caddr = $urandom;
      end
      wdok = (m_owner.size() != 0);
      wrd  = $urandom;
    end
    chk1("t4_uncached_seen", nunc >= 5, 1'b1);
    rr = 0; cr = 0; waok = 0;
    drain();

    // Full FIFO
    rr = 1; waok = 1; wdok = 0;
    for (int i = 0; i < 4; i++) begin
      raddr = 32'h8000_0000 + 32'(i * 4);
      settle(); chk1("t5_fill_addr_ok", ram_data_addr_ok, 1'b1);
      step();
    end
    raddr = 32'h8000_0100;
    repeat (2) begin
      settle();
      chk1("t5_full_addr_ok", ram_data_addr_ok, 1'b0);
      chk1("t5_full_wrap_req", wrap_data_req, 1'b0);
      step();
    end
    wdok = 1; wrd = 32'h0BAD_F00D;
    settle();
    chk1("t5_pop_cycle_addr_ok", ram_data_addr_ok, 1'b0);
    chk1("t5_pop_data_ok", ram_data_data_ok, 1'b1);
    step(); wdok = 0;
    settle();
    chk1("t5_after_pop_addr_ok", ram_data_addr_ok, 1'b1);
    step(); rr = 0; waok = 0;
    drain();

    // Reset mid-flight
    rr = 1; waok = 1;
    for (int i = 0; i < 3; i++) begin
      raddr = 32'h9000_0000 + 32'(i * 4);
      step();
    end
    rr = 0; cr = 1; caddr = 32'hBFAF_0000; waok = 0;
    step(); step();
    rst = 1; wdok = 1; wrd = 32'h5A5A_5A5A;
    settle();
    chk1("t6_rst_wrap_req", wrap_data_req, 1'b0);
    chk1("t6_rst_conf_addr_ok", conf_data_addr_ok, 1'b0);
    chk1("t6_rst_ram_data_ok", ram_data_data_ok, 1'b0);
    chk1("t6_rst_conf_data_ok", conf_data_data_ok, 1'b0);
    step();
    rst = 0; wdok = 0; cr = 1; caddr = 32'hBFAF_0040; waok = 1;
    settle();
    chk1("t6_fresh_conf_accept", conf_data_addr_ok, 1'b1);
    chk32("t6_fresh_addr", wrap_data_addr, 32'hBFAF_0040);
    step(); cr = 0; waok = 0; wdok = 1; wrd = 32'hC0FF_EE00;
    settle();
    chk1("t6_conf_data_ok", conf_data_data_ok, 1'b1);
    chk1("t6_no_stale_ram", ram_data_data_ok, 1'b0);
    step(); wdok = 0;

    // Randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      if (!rr || acc_r) begin
        rr = 1'($urandom_range(0, 1)); rwr = 1'($urandom_range(0, 1));
        rsz = 2'($urandom_range(0, 2)); raddr = $urandom; rwd = $urandom;
      end
      if (!cr || acc_c) begin
        cr = 1'($urandom_range(0, 1)); cwr = 1'($urandom_range(0, 1));
        csz = 2'($urandom_range(0, 2)); caddr = $urandom; cwd = $urandom;
      end
      waok = ($urandom_range(0, 3) != 0);
      wdok = (m_owner.size() != 0) && ($urandom_range(0, 2) != 0);
      wrd  = $urandom;
      rst  = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0; rr = 0; cr = 0; waok = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
